// File: rtl/mult_32bit_pkg.sv
`default_nettype none
// ============================================================================
// mult_32bit_pkg : shared widths, iteration count, FSM states, magnitude helper
// Revision: 1.0
// ============================================================================
package mult_32bit_pkg;

   localparam int WORD_WIDTH = 32;
   localparam int ITERATIONS = 32;
   localparam int CNT_WIDTH  = 6;
   localparam int ACC_WIDTH  = 2 * WORD_WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Two's-complement magnitude; 0x80000000 maps to 2^31, which still fits unsigned.
   function automatic logic [WORD_WIDTH-1:0] magnitude(input logic [WORD_WIDTH-1:0] v,
                                                       input logic sgn);
      return (sgn && v[WORD_WIDTH-1]) ? (~v + 1'b1) : v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mult_32bit_step.sv
`default_nettype none
// ============================================================================
// mult_32bit_step : one combinational shift-and-add iteration
// Revision: 1.0
// ============================================================================
module mult_32bit_step
   import mult_32bit_pkg::*;
(
   input  logic [ACC_WIDTH-1:0]  acc_i,
   input  logic [WORD_WIDTH-1:0] mcand_i,
   input  logic                  lsb_i,
   output logic [ACC_WIDTH-1:0]  acc_o
);

   logic [WORD_WIDTH:0] w_sum;

   // Upper half plus a 33-bit sum cannot overflow: the top bit is zero after each shift.
   assign w_sum = acc_i[ACC_WIDTH-1:WORD_WIDTH] + (lsb_i ? {1'b0, mcand_i} : '0);
   assign acc_o = {1'b0, w_sum, acc_i[WORD_WIDTH-1:1]};

endmodule

`default_nettype wire

// File: rtl/mult_32bit.sv
`default_nettype none
// ============================================================================
// mult_32bit : iterative 32x32 -> 64 signed/unsigned multiplier, 32 cycles/op
// Revision: 1.0
// ============================================================================
module mult_32bit
   import mult_32bit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic             is_signed_i,
   input  logic [WIDTH-1:0] value1_i,
   input  logic [WIDTH-1:0] value2_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic [WORD_WIDTH-1:0]  mcand_q, mcand_d;
   logic                   neg_q, neg_d;
   logic [WORD_WIDTH-1:0]  hi_q, hi_d;
   logic [WORD_WIDTH-1:0]  lo_q, lo_d;

   logic [ACC_WIDTH-1:0]    w_acc_next;
   logic [2*WORD_WIDTH-1:0] w_prod;
   logic [2*WORD_WIDTH-1:0] w_result;
   logic                    w_accept;

   mult_32bit_step u_step (
      .acc_i   (acc_q),
      .mcand_i (mcand_q),
      .lsb_i   (acc_q[0]),
      .acc_o   (w_acc_next)
   );

   assign w_prod   = w_acc_next[2*WORD_WIDTH-1:0];
   assign w_result = neg_q ? (~w_prod + 1'b1) : w_prod;
   assign w_accept = start_i && (state_q != RUN);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      neg_d   = neg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (w_accept) begin
               state_d = RUN;
               cnt_d   = '0;
               mcand_d = magnitude(value1_i, is_signed_i);
               acc_d   = {{(WORD_WIDTH+1){1'b0}}, magnitude(value2_i, is_signed_i)};
               neg_d   = is_signed_i && (value1_i[WORD_WIDTH-1] ^ value2_i[WORD_WIDTH-1]);
            end
         end
         RUN: begin
            acc_d = w_acc_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_WIDTH'(ITERATIONS - 1)) begin
               state_d      = DONE;
               {hi_d, lo_d} = w_result;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         mcand_q <= '0;
         neg_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         neg_q   <= neg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy_o = (state_q == RUN);
   assign done_o = (state_q == DONE);
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_32bit.sv
`default_nettype none
// ============================================================================
// tb_mult_32bit : randomized bench for mult_32bit against a 64-bit product model
// Revision: 1.0
// ============================================================================
module tb_mult_32bit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic [31:0] value1 = '0;
   logic [31:0] value2 = '0;
   logic        busy_o, done_o;
   logic [31:0] hi_o, lo_o;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   mult_32bit #(.WIDTH(32)) dut (
      .clock_i     (clock),
      .reset_i     (reset),
      .start_i     (start),
      .is_signed_i (is_signed),
      .value1_i    (value1),
      .value2_i    (value2),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .hi_o        (hi_o),
      .lo_o        (lo_o)
   );

   always #5 clock = ~clock;

   function automatic logic [63:0] ref_prod(input bit sg, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ea, eb;
      ea = sg ? {{32{a[31]}}, a} : {32'b0, a};
      eb = sg ? {{32{b[31]}}, b} : {32'b0, b};
      return ea * eb;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         if (fails <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a pending product completes exactly 32 edges after acceptance.
   bit          m_pend = 1'b0;
   bit          m_done = 1'b0;
   logic [63:0] m_out  = '0;
   logic [63:0] m_prod = '0;
   longint      m_due  = 0;
   longint      cyc    = 0;

   always @(posedge clock) begin
      bit acc_now;
      if (reset) begin
         m_pend = 1'b0;
         m_done = 1'b0;
         m_out  = '0;
      end else begin
         acc_now = start && !m_pend;
         m_done  = 1'b0;
         if (m_pend && cyc == m_due) begin
            m_done = 1'b1;
            m_out  = m_prod;
            m_pend = 1'b0;
         end
         if (acc_now) begin
            m_pend = 1'b1;
            m_due  = cyc + 32;
            m_prod = ref_prod(is_signed, value1, value2);
         end
      end
      cyc++;
   end

   always @(negedge clock) begin
      if (chk_en) begin
         chk("busy", 64'(busy_o), 64'(m_pend));
         chk("done", 64'(done_o), 64'(m_done));
         chk("hilo", {hi_o, lo_o}, m_out);
      end
   end

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic do_op(input bit sg, input logic [31:0] a, input logic [31:0] b,
                        input bit chain, input bit junk,
                        output logic [63:0] res, output int lat);
      if (!chain) @(negedge clock);
      start = 1'b1; is_signed = sg; value1 = a; value2 = b;
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
         start     = junk && (lat < 32) && ($urandom_range(0, 3) == 0);
         is_signed = 1'($urandom);
         value1    = $urandom;
         value2    = $urandom;
      end while (!done_o && lat < 40);
      start = 1'b0;
      res = {hi_o, lo_o};
   endtask

   initial begin
      logic [63:0] r;
      int          lat;
      int          ndone;

      chk("pin_u3x5",  ref_prod(0, 32'd3, 32'd5), 64'h0000_0000_0000_000F);
      chk("pin_uffff", ref_prod(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
      chk("pin_sm1x5", ref_prod(1, 32'hFFFF_FFFF, 32'd5), 64'hFFFF_FFFF_FFFF_FFFB);
      chk("pin_s8000", ref_prod(1, 32'h8000_0000, 32'h8000_0000), 64'h4000_0000_0000_0000);

      repeat (3) @(negedge clock);
      chk_en = 1'b1;
      reset  = 1'b0;
      chk("reset_state", {30'b0, busy_o, done_o, hi_o, lo_o}, 64'h0);

      do_op(0, 32'd3, 32'd5, 0, 0, r, lat);
      chk("u3x5", r, 64'h0000_0000_0000_000F);
      chk("u3x5_lat", 64'(lat), 64'd33);
      do_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, r, lat);
      chk("uffff", r, 64'hFFFF_FFFE_0000_0001);
      do_op(1, 32'hFFFF_FFFF, 32'd5, 0, 0, r, lat);
      chk("sm1x5", r, 64'hFFFF_FFFF_FFFF_FFFB);
      do_op(1, 32'h8000_0000, 32'h8000_0000, 0, 0, r, lat);
      chk("s8000", r, 64'h4000_0000_0000_0000);

      // A start pulse mid-run must be ignored; a start in the DONE cycle chains directly.
      @(negedge clock);
      start = 1'b1; is_signed = 1'b0; value1 = 32'd2; value2 = 32'd9;
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
         start = (lat == 5); value1 = 32'd7; value2 = 32'd7;
      end while (!done_o && lat < 40);
      start = 1'b0;
      chk("ign_lat", 64'(lat), 64'd33);
      chk("ign_lo", {hi_o, lo_o}, 64'h12);
      do_op(0, 32'd4, 32'd4, 1, 0, r, lat);
      chk("chain_lat", 64'(lat), 64'd33);
      chk("chain_res", r, 64'd16);

      // Reset mid-run aborts without a done pulse.
      @(negedge clock);
      start = 1'b1; is_signed = 1'b0; value1 = 32'd6; value2 = 32'd7;
      @(negedge clock);
      start = 1'b0;
      repeat (9) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("abort_state", {30'b0, busy_o, done_o, hi_o, lo_o}, 64'h0);
      ndone = 0;
      repeat (40) begin
         @(negedge clock);
         if (done_o) ndone++;
      end
      chk("abort_no_done", 64'(ndone), 64'd0);

      for (int i = 0; i < 1000; i++) begin
         bit          sg, chain, junk;
         logic [31:0] a, b;
         sg    = 1'($urandom_range(0, 1));
         a     = pick();
         b     = pick();
         chain = ($urandom_range(0, 3) == 0);
         junk  = 1'($urandom_range(0, 1));
         do_op(sg, a, b, chain, junk, r, lat);
         chk("rand_res", r, ref_prod(sg, a, b));
         chk("rand_lat", 64'(lat), 64'd33);
      end

      repeat (3) @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
